// File: rtl/led_shift_receiver.sv
`default_nettype none
// ============================================================================
// Module   : led_shift_receiver
// Purpose  : Receive-side model of the LED driver shift-register chain.
//            Synchronizes the controller's serial_clk / serial_in /
//            latch_enable / output_enable_n, shifts data MSB first, latches
//            it to the LED outputs, drives a daisy-chain serial_out, flags
//            frame integrity and measures output-enable duty per window.
// Ports    : clk, reset_n (async, active low)
//            serial_clk, serial_in, latch_enable, output_enable_n (async in)
//            led_out[WIDTH-1:0]  latched LEDs gated by output enable
//            serial_out          daisy-chain data (shift register MSB)
//            frame_valid/_error  1-cycle latch pulses (bit count == / != WIDTH)
//            duty_out[7:0]       enable-low cycles in last complete window
//            duty_valid          1-cycle pulse when duty_out updates
// Options  : `define LED_RX_FRAME_CHECK_EN to enable the shifted-bit counter.
//            Without it frame_error is 0 and frame_valid pulses on every latch.
// Revision : 1.0 - initial release
// ============================================================================
module led_shift_receiver #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DUTY_WINDOW = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             serial_clk,
  input  logic             serial_in,
  input  logic             latch_enable,
  input  logic             output_enable_n,
  output logic [WIDTH-1:0] led_out,
  output logic             serial_out,
  output logic             frame_valid,
  output logic             frame_error,
  output logic [7:0]       duty_out,
  output logic             duty_valid
);

  localparam logic [7:0] LAST_WIN = 8'(DUTY_WINDOW - 1);

  // --------------------------------------------------------------------------
  // Input synchronizers (index SYNC_STAGES-1 is the synchronized value)
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, le_sync_q, oe_sync_q;
  logic                   sck_prev_q, le_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      le_sync_q  <= '0;
      oe_sync_q  <= '1;
      sck_prev_q <= 1'b0;
      le_prev_q  <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], serial_clk};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], serial_in};
      le_sync_q  <= {le_sync_q[SYNC_STAGES-2:0], latch_enable};
      oe_sync_q  <= {oe_sync_q[SYNC_STAGES-2:0], output_enable_n};
      sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
      le_prev_q  <= le_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, sdi_s, le_s, oe_s;
  logic shift_edge, latch_edge;

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s      = sdi_sync_q[SYNC_STAGES-1];
  assign le_s       = le_sync_q[SYNC_STAGES-1];
  assign oe_s       = oe_sync_q[SYNC_STAGES-1];
  assign shift_edge = sck_s & ~sck_prev_q;
  assign latch_edge = le_s & ~le_prev_q;

  // --------------------------------------------------------------------------
  // Frame integrity: count shifted bits since the last latch
  // --------------------------------------------------------------------------
  logic frame_ok;

`ifdef LED_RX_FRAME_CHECK_EN
  localparam int CNT_W = $clog2(2 * WIDTH + 1);
  logic [CNT_W-1:0] bit_count_q, bit_count_d;

  always_comb begin
    bit_count_d = bit_count_q;
    if (latch_edge) begin
      // A shift coinciding with the latch belongs to the next frame.
      bit_count_d = shift_edge ? CNT_W'(1) : '0;
    end else if (shift_edge && (bit_count_q != CNT_W'(2 * WIDTH))) begin
      bit_count_d = bit_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_count_q <= '0;
    end else begin
      bit_count_q <= bit_count_d;
    end
  end

  assign frame_ok = (bit_count_q == CNT_W'(WIDTH));
`else
  assign frame_ok = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Shift register, output latch, LED / daisy-chain outputs, frame flags
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] shift_reg_q, latched_q, led_q;
  logic             serial_out_q, frame_valid_q, frame_error_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg_q   <= '0;
      latched_q     <= '0;
      led_q         <= '0;
      serial_out_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      if (shift_edge) begin
        shift_reg_q <= {shift_reg_q[WIDTH-2:0], sdi_s};
      end
      // Latch captures the pre-shift value when both edges coincide.
      if (latch_edge) begin
        latched_q <= shift_reg_q;
      end
      led_q         <= oe_s ? '0 : latched_q;
      serial_out_q  <= shift_reg_q[WIDTH-1];
      frame_valid_q <= latch_edge & frame_ok;
      frame_error_q <= latch_edge & ~frame_ok;
    end
  end

  // --------------------------------------------------------------------------
  // Duty measurement over a free-running window
  // --------------------------------------------------------------------------
  logic [7:0] win_q, on_count_q, duty_q;
  logic [7:0] on_sum;
  logic       win_last, duty_valid_q;

  assign win_last = (win_q == LAST_WIN);
  // The last window cycle is included in the reported count.
  assign on_sum   = on_count_q + {7'd0, ~oe_s};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q        <= '0;
      on_count_q   <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
    end else begin
      duty_valid_q <= win_last;
      if (win_last) begin
        win_q      <= '0;
        on_count_q <= '0;
        duty_q     <= on_sum;
      end else begin
        win_q      <= win_q + 8'd1;
        on_count_q <= on_sum;
      end
    end
  end

  assign led_out     = led_q;
  assign serial_out  = serial_out_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign duty_out    = duty_q;
  assign duty_valid  = duty_valid_q;

endmodule
`default_nettype wire
